// File: rtl/core_pkg.sv
// Shared control-path types for the multi-cycle core: FSM states, instruction
// field encodings and write-back select codes.
package core_pkg;

    typedef enum logic [3:0] {
        RESET_S  = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_DP  = 4'd3,
        ALU_WB   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WB   = 4'd7,
        MEM_WR   = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        OP_DATA    = 2'b00,
        OP_MEM     = 2'b01,
        OP_BRANCH  = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_type_t;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
        COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
        COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
        COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
    } cond_t;

    localparam logic [3:0] OPC_TST = 4'b1000;
    localparam logic [3:0] OPC_TEQ = 4'b1001;
    localparam logic [3:0] OPC_CMP = 4'b1010;
    localparam logic [3:0] OPC_CMN = 4'b1011;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    // Compare-class opcodes only update flags and never write a register.
    function automatic logic isCompare(input logic [3:0] opc);
        return (opc == OPC_TST) || (opc == OPC_TEQ) || (opc == OPC_CMP) || (opc == OPC_CMN);
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_cond_check.sv
// Combinational evaluation of the 4-bit condition field against NZCV flags.
module cond_check
    import core_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        pass = 1'b0;
        case (cond_t'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the core.
// Define PERF_COUNTERS_EN to add the cycle_count / instr_retired counters.
module multicycle_control_fsm
    import core_pkg::*;
#(
    parameter int         CNT_W  = 32,
    parameter logic [3:0] LR_IDX = 4'd14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic [3:0]  flags,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        reg_write,
    output logic        rd_sel,
    output logic [1:0]  wb_sel,
    output logic        alu_src_imm,
    output logic        flags_write,
    output logic        illegal
`ifdef PERF_COUNTERS_EN
    ,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_retired
`endif
);

    // The link register index is consumed by the datapath's rd mux.
    if (LR_IDX == 4'd15) begin : gBadLrIdx
        $error("LR_IDX must not alias the PC");
    end
    if (CNT_W < 1) begin : gBadCntW
        $error("CNT_W must be at least 1");
    end

    state_t     state, nextState;
    logic       condPass;
    op_type_t   opType;
    logic [3:0] opCode;
    logic       unusedOk;

    assign opType   = op_type_t'(instruction[27:26]);
    assign opCode   = instruction[24:21];
    assign unusedOk = ^instruction[19:0];

    cond_check uCondCheck (
        .cond  (instruction[31:28]),
        .flags (flags),
        .pass  (condPass)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= RESET_S;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            RESET_S:  nextState = FETCH;
            FETCH:    if (mem_ready) nextState = DECODE;
            DECODE: begin
                if (!condPass) nextState = FETCH;
                else begin
                    case (opType)
                        OP_DATA:   nextState = EXEC_DP;
                        OP_MEM:    nextState = MEM_ADDR;
                        OP_BRANCH: nextState = BRANCH;
                        default:   nextState = FETCH;
                    endcase
                end
            end
            EXEC_DP:  nextState = ALU_WB;
            ALU_WB:   nextState = FETCH;
            MEM_ADDR: nextState = instruction[20] ? MEM_RD : MEM_WR;
            MEM_RD:   if (mem_ready) nextState = MEM_WB;
            MEM_WB:   nextState = FETCH;
            MEM_WR:   if (mem_ready) nextState = FETCH;
            BRANCH:   nextState = FETCH;
            default:  nextState = RESET_S;
        endcase
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        addr_sel    = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        reg_write   = 1'b0;
        rd_sel      = 1'b0;
        wb_sel      = WB_ALU;
        alu_src_imm = 1'b0;
        flags_write = 1'b0;
        illegal     = 1'b0;
        // Reset masks the current state so an aborted access issues no writes.
        if (!rst) begin
            case (state)
                FETCH: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                DECODE:  illegal = condPass && (opType == OP_ILLEGAL);
                EXEC_DP: alu_src_imm = instruction[25];
                ALU_WB: begin
                    reg_write   = !isCompare(opCode);
                    flags_write = instruction[20] || isCompare(opCode);
                end
                MEM_ADDR: alu_src_imm = !instruction[25];
                MEM_RD: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                end
                MEM_WB: begin
                    reg_write = 1'b1;
                    wb_sel    = WB_MEM;
                end
                MEM_WR: begin
                    mem_req  = 1'b1;
                    mem_we   = 1'b1;
                    addr_sel = 1'b1;
                end
                BRANCH: begin
                    pc_write = 1'b1;
                    pc_src   = 1'b1;
                    if (instruction[24]) begin
                        reg_write = 1'b1;
                        rd_sel    = 1'b1;
                        wb_sel    = WB_PC;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PERF_COUNTERS_EN
    logic retire;
    assign retire = (nextState == FETCH) &&
                    (state inside {DECODE, ALU_WB, MEM_WB, MEM_WR, BRANCH});

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count   <= '0;
            instr_retired <= '0;
        end else begin
            cycle_count <= cycle_count + 1'b1;
            if (retire) instr_retired <= instr_retired + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: the driver queues the hand-derived output vector for each
// cycle; a negedge monitor pops and compares it against the DUT outputs.
module tb_multicycle_control_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instruction = '0;
    logic [3:0]  flags = '0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src;
    logic        reg_write, rd_sel, alu_src_imm, flags_write, illegal;
    logic [1:0]  wb_sel;
`ifdef PERF_COUNTERS_EN
    logic [31:0] cycle_count, instr_retired;
`endif

    multicycle_control_fsm dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .flags       (flags),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .addr_sel    (addr_sel),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .reg_write   (reg_write),
        .rd_sel      (rd_sel),
        .wb_sel      (wb_sel),
        .alu_src_imm (alu_src_imm),
        .flags_write (flags_write),
        .illegal     (illegal)
`ifdef PERF_COUNTERS_EN
        ,
        .cycle_count   (cycle_count),
        .instr_retired (instr_retired)
`endif
    );

    always #5 clk = ~clk;

    // Output vector bits: req we asel irw pcw pcsrc regw rdsel wb[1:0] aimm fw ill
    localparam logic [12:0] REQ   = 13'h1000;
    localparam logic [12:0] WE    = 13'h0800;
    localparam logic [12:0] ASEL  = 13'h0400;
    localparam logic [12:0] IRW   = 13'h0200;
    localparam logic [12:0] PCW   = 13'h0100;
    localparam logic [12:0] PCS   = 13'h0080;
    localparam logic [12:0] RGW   = 13'h0040;
    localparam logic [12:0] RDS   = 13'h0020;
    localparam logic [12:0] WBPC  = 13'h0010;
    localparam logic [12:0] WBMEM = 13'h0008;
    localparam logic [12:0] AIMM  = 13'h0004;
    localparam logic [12:0] FW    = 13'h0002;
    localparam logic [12:0] ILL   = 13'h0001;
    localparam logic [12:0] NONE  = 13'h0000;
    localparam logic [12:0] FOK   = REQ | IRW | PCW;

    localparam logic [31:0] ADD_I  = 32'hE282_1005;
    localparam logic [31:0] ADDS_I = 32'hE292_1005;
    localparam logic [31:0] CMPS   = 32'hE152_0003;
    localparam logic [31:0] CMP_NS = 32'hE142_0003;
    localparam logic [31:0] TST_NS = 32'hE100_0000;
    localparam logic [31:0] ORR_NS = 32'hE180_0000;
    localparam logic [31:0] BEQ    = 32'h0A00_0004;
    localparam logic [31:0] BL     = 32'hEB00_0010;
    localparam logic [31:0] LDR    = 32'hE591_2000;
    localparam logic [31:0] STR    = 32'hE581_2000;
    localparam logic [31:0] UNDEF  = 32'hEC00_0000;
    localparam logic [31:0] UNDEFN = 32'h1C00_0000;
    localparam logic [31:0] BNV    = 32'hFA00_0004;
    localparam logic [31:0] BGT    = 32'hCA00_0000;
    localparam logic [31:0] BLS    = 32'h9A00_0000;
    localparam logic [31:0] BHI    = 32'h8A00_0000;
    localparam logic [31:0] BGE    = 32'hAA00_0000;

    typedef struct {
        string       tag;
        logic [12:0] exp;
    } exp_t;

    exp_t        sbq[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [12:0] act;

    assign act = {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
                  reg_write, rd_sel, wb_sel, alu_src_imm, flags_write, illegal};

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            vectors++;
            if (act !== e.exp) begin
                miscompares++;
                $display("FAIL %s: outputs %013b, required %013b", e.tag, act, e.exp);
            end
        end
    end

    task automatic cyc(input string tag, input logic r, input logic [31:0] ins,
                       input logic [3:0] f, input logic rdy, input logic [12:0] e);
        exp_t item;
        rst         = r;
        instruction = ins;
        flags       = f;
        mem_ready   = rdy;
        item.tag    = tag;
        item.exp    = e;
        sbq.push_back(item);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        cyc("reset_0", 1, ADD_I, 4'h0, 1, NONE);
        cyc("reset_1", 1, ADD_I, 4'h0, 1, NONE);
        cyc("reset_s", 0, ADD_I, 4'h0, 1, NONE);

        // ADD immediate, with a two-cycle fetch stall first
        cyc("fetch_wait0", 0, ADD_I, 4'h0, 0, REQ);
        cyc("fetch_wait1", 0, ADD_I, 4'h0, 0, REQ);
        cyc("add_fetch",   0, ADD_I, 4'h0, 1, FOK);
        cyc("add_decode",  0, ADD_I, 4'h0, 1, NONE);
        cyc("add_exec",    0, ADD_I, 4'h0, 1, AIMM);
        cyc("add_wb",      0, ADD_I, 4'h0, 1, RGW);

        cyc("adds_fetch",  0, ADDS_I, 4'h0, 1, FOK);
        cyc("adds_decode", 0, ADDS_I, 4'h0, 1, NONE);
        cyc("adds_exec",   0, ADDS_I, 4'h0, 1, AIMM);
        cyc("adds_wb",     0, ADDS_I, 4'h0, 1, RGW | FW);

        cyc("cmps_fetch",  0, CMPS, 4'h0, 1, FOK);
        cyc("cmps_decode", 0, CMPS, 4'h0, 1, NONE);
        cyc("cmps_exec",   0, CMPS, 4'h0, 1, NONE);
        cyc("cmps_wb",     0, CMPS, 4'h0, 1, FW);

        cyc("cmp_fetch",   0, CMP_NS, 4'h0, 1, FOK);
        cyc("cmp_decode",  0, CMP_NS, 4'h0, 1, NONE);
        cyc("cmp_exec",    0, CMP_NS, 4'h0, 1, NONE);
        cyc("cmp_wb",      0, CMP_NS, 4'h0, 1, FW);

        cyc("tst_fetch",   0, TST_NS, 4'h0, 1, FOK);
        cyc("tst_decode",  0, TST_NS, 4'h0, 1, NONE);
        cyc("tst_exec",    0, TST_NS, 4'h0, 1, NONE);
        cyc("tst_wb",      0, TST_NS, 4'h0, 1, FW);

        cyc("orr_fetch",   0, ORR_NS, 4'h0, 1, FOK);
        cyc("orr_decode",  0, ORR_NS, 4'h0, 1, NONE);
        cyc("orr_exec",    0, ORR_NS, 4'h0, 1, NONE);
        cyc("orr_wb",      0, ORR_NS, 4'h0, 1, RGW);

        // Conditional branches: skipped ones return to FETCH straight from DECODE
        cyc("beq_z0_fetch",  0, BEQ, 4'b0000, 1, FOK);
        cyc("beq_z0_decode", 0, BEQ, 4'b0000, 1, NONE);
        cyc("beq_z1_fetch",  0, BEQ, 4'b0100, 1, FOK);
        cyc("beq_z1_decode", 0, BEQ, 4'b0100, 1, NONE);
        cyc("beq_z1_branch", 0, BEQ, 4'b0100, 1, PCW | PCS);

        cyc("bl_fetch",  0, BL, 4'h0, 1, FOK);
        cyc("bl_decode", 0, BL, 4'h0, 1, NONE);
        cyc("bl_branch", 0, BL, 4'h0, 1, PCW | PCS | RGW | RDS | WBPC);

        cyc("bgt_nv_fetch",  0, BGT, 4'b1000, 1, FOK);
        cyc("bgt_nv_decode", 0, BGT, 4'b1000, 1, NONE);
        cyc("bls_c_fetch",   0, BLS, 4'b0010, 1, FOK);
        cyc("bls_c_decode",  0, BLS, 4'b0010, 1, NONE);
        cyc("bhi_c_fetch",   0, BHI, 4'b0010, 1, FOK);
        cyc("bhi_c_decode",  0, BHI, 4'b0010, 1, NONE);
        cyc("bhi_c_branch",  0, BHI, 4'b0010, 1, PCW | PCS);
        cyc("bge_nv_fetch",  0, BGE, 4'b1001, 1, FOK);
        cyc("bge_nv_decode", 0, BGE, 4'b1001, 1, NONE);
        cyc("bge_nv_branch", 0, BGE, 4'b1001, 1, PCW | PCS);
        cyc("bnv_fetch",     0, BNV, 4'b1111, 1, FOK);
        cyc("bnv_decode",    0, BNV, 4'b1111, 1, NONE);

        // LDR with three wait cycles in MEM_RD
        cyc("ldr_fetch",  0, LDR, 4'h0, 1, FOK);
        cyc("ldr_decode", 0, LDR, 4'h0, 1, NONE);
        cyc("ldr_addr",   0, LDR, 4'h0, 1, AIMM);
        for (int i = 0; i < 3; i++) cyc($sformatf("ldr_wait%0d", i), 0, LDR, 4'h0, 0, REQ | ASEL);
        cyc("ldr_rd",     0, LDR, 4'h0, 1, REQ | ASEL);
        cyc("ldr_wb",     0, LDR, 4'h0, 1, RGW | WBMEM);

        cyc("str_fetch",  0, STR, 4'h0, 1, FOK);
        cyc("str_decode", 0, STR, 4'h0, 1, NONE);
        cyc("str_addr",   0, STR, 4'h0, 1, AIMM);
        for (int i = 0; i < 2; i++) cyc($sformatf("str_wait%0d", i), 0, STR, 4'h0, 0, REQ | WE | ASEL);
        cyc("str_wr",     0, STR, 4'h0, 1, REQ | WE | ASEL);

        cyc("undef_fetch",   0, UNDEF, 4'h0, 1, FOK);
        cyc("undef_decode",  0, UNDEF, 4'h0, 1, ILL);
        cyc("undefn_fetch",  0, UNDEFN, 4'b0100, 1, FOK);
        cyc("undefn_decode", 0, UNDEFN, 4'b0100, 1, NONE);

        // Reset while a load is waiting on memory
        cyc("ldr2_fetch",  0, LDR, 4'h0, 1, FOK);
        cyc("ldr2_decode", 0, LDR, 4'h0, 1, NONE);
        cyc("ldr2_addr",   0, LDR, 4'h0, 1, AIMM);
        cyc("ldr2_wait",   0, LDR, 4'h0, 0, REQ | ASEL);
        cyc("ldr2_rst",    1, LDR, 4'h0, 1, NONE);
        cyc("ldr2_reset_s", 0, LDR, 4'h0, 1, NONE);
        cyc("post_fetch",  0, ADD_I, 4'h0, 1, FOK);
        cyc("post_decode", 0, ADD_I, 4'h0, 1, NONE);

        repeat (2) @(posedge clk);
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d vectors left unchecked, required 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
